// File: rtl/rr_arbiter_8to3.sv
// rr_arbiter_8to3: eight-way round-robin arbiter feeding a 3-to-8 decoder.
// The winner's index and an enable are registered so the decoder never sees
// a combinational path from the request lines. A grant ends when its owner
// drops its request or when the hold limit is reached. Either way the enable
// is low for at least one cycle before the next owner, so two decoder outputs
// can never overlap.
module rr_arbiter_8to3 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic       grant_en,
  output logic [2:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state;
  logic [2:0]         ptr;
  logic [CNT_W-1:0]   hold_cnt;

  logic [7:0]         req_rot;
  logic [2:0]         offset;
  logic [2:0]         winner;
  logic               any_req;

  // Rotate the request vector so bit 0 is the requester at ptr. The lowest set
  // bit of the rotated vector is then the nearest requester in ascending
  // modular order, and adding ptr back (3-bit wrap) gives its real index.
  always_comb begin
    req_rot = '0;
    offset  = '0;
    for (int i = 0; i < 8; i++) begin
      req_rot[i] = req[ptr + 3'(i)];
    end
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = 3'(i);
      end
    end
    winner  = ptr + offset;
    any_req = |req;
  end

  // Arbitration FSM with registered outputs. The pointer only moves when a
  // grant ends, to one past the previous owner, which keeps service fair.
  // Release is tested before the hold limit so that a requester letting go on
  // its last allowed cycle is not reported as a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      grant_en  <= 1'b0;
      grant_idx <= 3'd0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= winner;
            grant_en  <= 1'b1;
            busy      <= 1'b1;
            hold_cnt  <= CNT_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req[grant_idx]) begin
            grant_en <= 1'b0;
            busy     <= 1'b0;
            ptr      <= grant_idx + 3'd1;
            state    <= IDLE;
          end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
            grant_en <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            ptr      <= grant_idx + 3'd1;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          grant_en <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// tb_rr_arbiter_8to3: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against an arbitration model.
module tb_rr_arbiter_8to3;

  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [7:0] req;
    logic       en;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       grant_en;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int passes = 0;

  // Reference model: who owns the grant, how long they have had it, and
  // where the round-robin search starts next time.
  bit m_en;
  bit m_to;
  int m_idx;
  int m_ptr;
  int m_hold;

  vec_t vecs[$];

  rr_arbiter_8to3 #(
    .MAX_HOLD(MAX_HOLD),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant_en (grant_en),
    .grant_idx(grant_idx),
    .busy     (busy),
    .timeout  (timeout)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    m_en   = 1'b0;
    m_to   = 1'b0;
    m_idx  = 0;
    m_ptr  = 0;
    m_hold = 0;
  endtask

  task automatic modelStep(input logic [7:0] r);
    bit found;
    m_to  = 1'b0;
    found = 1'b0;
    if (!m_en) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found  = 1'b1;
          m_idx  = (m_ptr + k) % 8;
          m_en   = 1'b1;
          m_hold = 1;
        end
      end
    end else if (!r[m_idx]) begin
      m_en  = 1'b0;
      m_ptr = (m_idx + 1) % 8;
    end else if (m_hold >= MAX_HOLD) begin
      m_en  = 1'b0;
      m_to  = 1'b1;
      m_ptr = (m_idx + 1) % 8;
    end else begin
      m_hold++;
    end
  endtask

  task automatic checkOutput(input string name, input bit e, input logic [2:0] i, input bit t);
    logic [5:0] got;
    logic [5:0] exp;
    got = {grant_en, grant_idx, busy, timeout};
    exp = {e, i, e, t};
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got en=%0b idx=%0d busy=%0b to=%0b, expected en=%0b idx=%0d busy=%0b to=%0b",
               name, grant_en, grant_idx, busy, timeout, e, i, e, t);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    modelStep(r);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req = 8'h00;
    modelReset();
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("reset", 1'b0, 3'd0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic addVec(input logic [7:0] r, input logic e, input logic [2:0] i, input logic t);
    vec_t v;
    v.req = r;
    v.en  = e;
    v.idx = i;
    v.to  = t;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1;
    req = 8'h00;
    modelReset();

    // Directed table, starting from reset (ptr = 0).
    addVec(8'h04, 1, 3'd2, 0);
    addVec(8'h04, 1, 3'd2, 0);
    addVec(8'h04, 1, 3'd2, 0);
    addVec(8'h00, 0, 3'd2, 0);
    addVec(8'h00, 0, 3'd2, 0);
    addVec(8'h40, 1, 3'd6, 0);
    addVec(8'h00, 0, 3'd6, 0);
    addVec(8'h41, 1, 3'd0, 0);
    addVec(8'h41, 1, 3'd0, 0);
    addVec(8'h00, 0, 3'd0, 0);
    addVec(8'h00, 0, 3'd0, 0);
    addVec(8'h81, 1, 3'd7, 0);
    addVec(8'h01, 0, 3'd7, 0);
    addVec(8'h01, 1, 3'd0, 0);
    addVec(8'h03, 1, 3'd0, 0);
    addVec(8'h02, 0, 3'd0, 0);
    addVec(8'h02, 1, 3'd1, 0);
    addVec(8'h00, 0, 3'd1, 0);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h08, 0, 3'd3, 1);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h00, 0, 3'd3, 0);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h08, 1, 3'd3, 0);
    addVec(8'h00, 0, 3'd3, 0);
    addVec(8'h00, 0, 3'd3, 0);

    doReset();
    foreach (vecs[n]) begin
      applyStimulus(vecs[n].req);
      checkOutput($sformatf("vector[%0d]", n), vecs[n].en, vecs[n].idx, vecs[n].to);
    end

    // All requesters held: grants rotate 0..7,0, each MAX_HOLD cycles long,
    // followed by one gap cycle carrying the timeout pulse.
    doReset();
    for (int g = 0; g < 9; g++) begin
      for (int p = 0; p <= MAX_HOLD; p++) begin
        applyStimulus(8'hFF);
        checkOutput($sformatf("rotate g%0d p%0d", g, p), p < MAX_HOLD, 3'(g % 8), p == MAX_HOLD);
      end
    end

    // Asynchronous reset in the middle of a grant to requester 5.
    doReset();
    applyStimulus(8'h20);
    checkOutput("grant5", 1'b1, 3'd5, 1'b0);
    applyStimulus(8'h20);
    checkOutput("grant5 hold", 1'b1, 3'd5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset", 1'b0, 3'd0, 1'b0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h20);
    checkOutput("after async reset", 1'b1, 3'd5, 1'b0);
    applyStimulus(8'h00);
    checkOutput("after async release", 1'b0, 3'd5, 1'b0);

    // Randomized traffic against the model; requests tend to persist for a
    // few cycles so hold limits are reached regularly.
    doReset();
    r = 8'h00;
    repeat (800) begin
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 3) == 0) r = 8'h00;
        else r = 8'($urandom_range(0, 255));
      end
      applyStimulus(r);
      checkOutput("random", m_en, 3'(m_idx), m_to);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8to3.md
Name: rr_arbiter_8to3

Overview:
- Eight-way round-robin arbiter that sits directly upstream of the 3-to-8 decoder.
- Eight request lines are arbitrated fairly. The winner's 3-bit index and an enable are presented in the form the decoder consumes: grant_idx maps to {s2,s1,s0} and grant_en maps to enable.
- A grant is held until its requester releases it, or until a programmable hold timeout expires.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one requester keeps the grant. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i is requester i's request. Level-sensitive, sampled on clk.
- grant_en  output  1  a grant is active; drives the decoder enable.
- grant_idx  output  3  index of the granted requester; drives decoder {s2,s1,s0}.
- busy  output  1  high while in GRANT state. Identical to grant_en; kept for status.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset: while rst is high, every register clears immediately.
  - grant_en=0, grant_idx=3'd0, busy=0, timeout=0.
  - Internal rr pointer ptr=3'd0, hold_cnt=0, state=IDLE.
  - A reset asserted mid-grant drops grant_en without waiting for a clock.
- All outputs are registered. There are no combinational paths from req to any output.
- States: IDLE, GRANT.
- IDLE:
  - If req==0: stay in IDLE; grant_en stays 0 and grant_idx holds its last value.
  - Else pick the first set bit searching ptr, ptr+1, ..., ptr+7 (mod 8, wrap 7->0).
  - At the next edge: grant_idx<=winner, grant_en<=1, hold_cnt<=1, state<=GRANT.
  - Latency: req seen at edge k gives grant_en=1 after edge k.
- GRANT: evaluated each edge.
  - If req[grant_idx]==0 (release): grant_en<=0, ptr<=grant_idx+1 (mod 8), state<=IDLE.
  - Else if hold_cnt==MAX_HOLD (limit): grant_en<=0, timeout<=1 for one cycle, ptr<=grant_idx+1, state<=IDLE.
  - Else: hold_cnt<=hold_cnt+1 and the grant stays.
  - A grant therefore lasts at most MAX_HOLD cycles.
- Mandatory gap: on every grant end, grant_en is low for at least one full cycle before the next grant. This prevents decoder output overlap between two owners.
- grant_idx stays stable for the whole of a grant. It changes only on the edge that raises grant_en.
- Other req bits changing during a grant have no effect until the return to IDLE.
- A requester that drops and re-raises within the gap cycle is arbitrated normally; ptr has already moved past it.
- Simultaneous requests: the winner is the one nearest ptr in ascending modular order. With all bits held, grants cycle 0,1,...,7,0,...
- timeout is high only on the single cycle after the limit edge and is 0 otherwise.
- Release and limit on the same edge: release takes priority, so timeout stays 0.

Test Plan:
- Reset with req=8'h00 held 5 cycles -> grant_en=0, grant_idx=0, busy=0, timeout=0 throughout.
- req=8'b0000_0100 for 3 cycles, then 0 -> grant_en rises 1 cycle after req with grant_idx=2 and stays high 3 cycles. grant_en falls the cycle after req drops and timeout stays 0.
- MAX_HOLD=4, req=8'hFF constant -> grant_idx sequence 0,1,...,7,0. Each grant lasts exactly 4 cycles with a 1-cycle gap. A timeout pulse occurs at each revocation.
- Wrap-around: grant idx 6 ends (ptr=7), then req=8'b0100_0001 -> next grant_idx=0, not 6.
- Release on the limit cycle (MAX_HOLD=4; req[3] drops on the 4th grant cycle) -> grant_en falls and timeout remains 0.
- Assert rst asynchronously mid-grant (grant_idx=5) -> grant_en=0 and grant_idx=0 before the next clk edge. After release, req=8'h20 gives grant_idx=5 (ptr restarted at 0).
